rfid_bit_fifo_wb: RTL and testbench

Wishbone responder that buffers demodulated RFID bits for the tag state controller. The demodulator pushes single bits into an internal FIFO. The controller, acting as Wishbone initiator with a 1-bit data bus and 3-bit address, pops bits, reads status, and clears flags through an 8-entry register map. An interrupt line tells the controller when data is pending or an overflow has occurred.

---
 rtl/rfid_bit_fifo_wb_if.sv | 13 +
 rtl/rfid_bit_fifo_wb.sv | 77 +++++++
 tb/tb_rfid_bit_fifo_wb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rfid_bit_fifo_wb_if.sv
// rfid_bit_fifo_wb_if: Wishbone bus bundle between the tag controller and the RFID bit FIFO
interface rfid_bit_fifo_wb_if;
    logic       cyc_i;
    logic       stb_i;
    logic [2:0] adr_i;
    logic       we_i;
    logic       dat_i;
    logic       dat_o;
    logic       ack_o;
    logic       inta_o;
    modport master (output cyc_i, stb_i, adr_i, we_i, dat_i, input dat_o, ack_o, inta_o);
    modport slave  (input cyc_i, stb_i, adr_i, we_i, dat_i, output dat_o, ack_o, inta_o);
endinterface

// File: rtl/rfid_bit_fifo_wb.sv
// rfid_bit_fifo_wb: Wishbone responder buffering demodulated RFID bits in a DEPTH x 1 FIFO
// with status/flag registers and a registered interrupt request.
module rfid_bit_fifo_wb #(
    parameter int DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rfid_bit_fifo_wb_if.slave wb,
    input  logic              bit_i,
    input  logic              bit_valid_i
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      lvl_q, lvl_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, irq_en_q, irq_en_d;
    logic             dat_q, dat_d, ack_q, ack_d, inta_q, inta_d;
    logic             req, rd, wr, w1, empty, full, half, pop, push, flush;
    logic [7:0]       rmap;

    always_comb begin
        empty    = lvl_q == '0;
        full     = lvl_q == (AW+1)'(DEPTH);
        half     = lvl_q >= (AW+1)'(DEPTH/2);
        req      = wb.cyc_i & wb.stb_i & ~ack_q;
        rd       = req & ~wb.we_i;
        wr       = req & wb.we_i;
        w1       = wr & wb.dat_i;
        pop      = rd && wb.adr_i == 3'd0 && !empty;
        flush    = w1 && wb.adr_i == 3'd6;
        // a pop in the same cycle frees the slot, so a push at full is still accepted
        push     = bit_valid_i & ~flush & (~full | pop);
        rmap     = {half, 1'b0, unf_q, irq_en_q, ovf_q, full, empty, ~empty & mem_q[rp_q]};
        mem_d    = mem_q;
        mem_d[wp_q] = push ? bit_i : mem_q[wp_q];
        wp_d     = flush ? '0 : wp_q + AW'(push);
        rp_d     = flush ? '0 : rp_q + AW'(pop);
        lvl_d    = flush ? '0 : lvl_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d    = (bit_valid_i & full & ~pop & ~flush) | (ovf_q & ~(w1 && wb.adr_i == 3'd3));
        unf_d    = (rd && wb.adr_i == 3'd0 && empty) | (unf_q & ~(w1 && wb.adr_i == 3'd5));
        irq_en_d = (wr && wb.adr_i == 3'd4) ? wb.dat_i : irq_en_q;
        dat_d    = rd ? rmap[wb.adr_i] : dat_q;
        ack_d    = req;
        inta_d   = irq_en_q & (~empty | ovf_q);
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wp_q     <= '0;
            rp_q     <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            dat_q    <= 1'b0;
            ack_q    <= 1'b0;
            inta_q   <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            lvl_q    <= lvl_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            inta_q   <= inta_d;
        end
    end

    assign wb.dat_o  = dat_q;
    assign wb.ack_o  = ack_q;
    assign wb.inta_o = inta_q;
endmodule

// File: tb/tb_rfid_bit_fifo_wb.sv
// tb_rfid_bit_fifo_wb: directed self-checking bench for the RFID bit FIFO Wishbone responder
module tb_rfid_bit_fifo_wb;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic bit_i = 1'b0;
    logic bit_valid_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    rfid_bit_fifo_wb_if wb();

    rfid_bit_fifo_wb #(.DEPTH(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .wb(wb),
        .bit_i(bit_i),
        .bit_valid_i(bit_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [2:0] a, input logic w, input logic d,
                        input logic bv, input logic b, output logic r);
        @(negedge clk_i);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.adr_i = a; wb.we_i = w; wb.dat_i = d;
        bit_valid_i = bv; bit_i = b;
        @(posedge clk_i); #1;
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0; bit_valid_i = 1'b0;
        chk("ack", wb.ack_o, 1);
        r = wb.dat_o;
        @(posedge clk_i); #1;
        chk("ack_pulse", wb.ack_o, 0);
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic exp);
        logic r;
        xfer(a, 1'b0, 1'b0, 1'b0, 1'b0, r);
        chk(tag, r, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic d);
        logic r;
        xfer(a, 1'b1, d, 1'b0, 1'b0, r);
    endtask

    task automatic push(input logic b);
        @(negedge clk_i);
        bit_valid_i = 1'b1; bit_i = b;
        @(negedge clk_i);
        bit_valid_i = 1'b0;
    endtask

    initial begin
        logic [16:0] pat;
        logic [15:0] pat2;
        logic [3:0]  seq;
        logic        r;
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.adr_i = '0; wb.we_i = 1'b0; wb.dat_i = 1'b0;
        pat  = 17'b1_0110_1001_1100_0101;
        pat2 = 16'h5A3C;
        seq  = 4'b1101;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", wb.ack_o, 0);
        chk("rst_dat", wb.dat_o, 0);
        chk("rst_inta", wb.inta_o, 0);
        @(negedge clk_i) rst_i = 1'b1;

        rd("empty0", 3'd1, 1'b1);
        rd("full0", 3'd2, 1'b0);
        rd("half0", 3'd7, 1'b0);
        rd("ovf0", 3'd3, 1'b0);
        rd("unf0", 3'd5, 1'b0);
        rd("irqen0", 3'd4, 1'b0);
        chk("inta0", wb.inta_o, 0);

        for (int i = 0; i < 4; i++) push(seq[i]);
        chk("inta_dis", wb.inta_o, 0);
        wr(3'd4, 1'b1);
        chk("inta_en", wb.inta_o, 1);
        for (int i = 0; i < 4; i++) rd($sformatf("pop4_%0d", i), 3'd0, seq[i]);
        rd("empty_after4", 3'd1, 1'b1);
        chk("inta_fall", wb.inta_o, 0);
        rd("irqen1", 3'd4, 1'b1);

        for (int i = 0; i < 17; i++) push(pat[i]);
        rd("full17", 3'd2, 1'b1);
        rd("ovf17", 3'd3, 1'b1);
        rd("half17", 3'd7, 1'b1);
        chk("inta17", wb.inta_o, 1);
        wr(3'd3, 1'b1);
        rd("ovf_clr", 3'd3, 1'b0);
        for (int i = 0; i < 16; i++) rd($sformatf("pop17_%0d", i), 3'd0, pat[i]);
        rd("empty17", 3'd1, 1'b1);

        for (int i = 0; i < 16; i++) push(pat2[i]);
        rd("full16", 3'd2, 1'b1);
        xfer(3'd0, 1'b0, 1'b0, 1'b1, ~pat2[15], r);
        chk("pop_push_full", r, pat2[0]);
        rd("full_kept", 3'd2, 1'b1);
        rd("ovf_kept0", 3'd3, 1'b0);
        for (int i = 1; i < 16; i++) rd($sformatf("popf_%0d", i), 3'd0, pat2[i]);
        rd("popf_new", 3'd0, ~pat2[15]);

        rd("empty_pop", 3'd0, 1'b0);
        rd("unf_set", 3'd5, 1'b1);
        wr(3'd5, 1'b1);
        rd("unf_clr", 3'd5, 1'b0);

        for (int i = 0; i < 7; i++) push(1'b1);
        rd("half7", 3'd7, 1'b0);
        push(1'b0);
        rd("half8", 3'd7, 1'b1);
        rd("flush_r", 3'd6, 1'b0);
        xfer(3'd6, 1'b1, 1'b1, 1'b1, 1'b1, r);
        rd("empty_flush", 3'd1, 1'b1);
        rd("ovf_flush", 3'd3, 1'b0);
        rd("empty_pop2", 3'd0, 1'b0);
        wr(3'd1, 1'b0);
        rd("ro_write", 3'd1, 1'b1);

        push(1'b1);
        @(negedge clk_i);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.adr_i = 3'd4; wb.we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mid_ack", wb.ack_o, 1);
        chk("mid_dat", wb.dat_o, 1);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_ack", wb.ack_o, 0);
        chk("rst_mid_dat", wb.dat_o, 0);
        chk("rst_mid_inta", wb.inta_o, 0);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b1;
        rd("empty_r", 3'd1, 1'b1);
        rd("full_r", 3'd2, 1'b0);
        rd("half_r", 3'd7, 1'b0);
        rd("ovf_r", 3'd3, 1'b0);
        rd("unf_r", 3'd5, 1'b0);
        rd("irqen_r", 3'd4, 1'b0);
        chk("inta_r", wb.inta_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
